multi_digit_counter: RTL and testbench

Parametrised multi-digit modulo counter for the 7-segment display path. It generalises the single-digit overflow counter to a chain of DIGITS stages, each counting modulo RADIX. The block adds up/down counting, synchronous clear and load, and a selectable wrap or saturate mode. Its per-digit output drives the display multiplexer/decoder directly, and its overflow output can cascade into a further counter or a timebase.

---
 rtl/multi_digit_counter_pkg.sv | 19 +
 rtl/multi_digit_counter_digit.sv | 53 +++++
 rtl/multi_digit_counter.sv | 68 ++++++
 tb/tb_multi_digit_counter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/multi_digit_counter_pkg.sv
// Shared types for the multi-digit modulo counter: digit field width, digit type,
// count direction and the load clamp helper.
package multi_digit_counter_pkg;

  localparam int DW = 4;

  typedef logic [DW-1:0] digit_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Loaded fields outside the digit range are pinned to the largest legal digit.
  function automatic digit_t clamp_digit(input digit_t v, input digit_t max_digit);
    return (v > max_digit) ? max_digit : v;
  endfunction

endpackage

// File: rtl/multi_digit_counter_digit.sv
// One modulo-RADIX digit stage: registered digit plus a combinational terminal flag
// (digit at RADIX-1 when counting up, at 0 when counting down).
module counter_digit
  import multi_digit_counter_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   step,
  input  logic   up,
  input  logic   clear,
  input  logic   load,
  input  digit_t load_digit,
  output digit_t digit,
  output logic   terminal
);

  localparam digit_t MAX_DIGIT = digit_t'(RADIX - 1);

  digit_t digit_reg;
  digit_t digit_next;
  dir_e   dir;

  assign dir = dir_e'(up);

  always_comb begin
    digit_next = digit_reg;
    if (clear) begin
      digit_next = '0;
    end else if (load) begin
      digit_next = clamp_digit(load_digit, MAX_DIGIT);
    end else if (step) begin
      if (dir == DIR_UP) begin
        digit_next = (digit_reg == MAX_DIGIT) ? '0 : digit_reg + 4'd1;
      end else begin
        digit_next = (digit_reg == '0) ? MAX_DIGIT : digit_reg - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_reg <= '0;
    end else begin
      digit_reg <= digit_next;
    end
  end

  assign digit    = digit_reg;
  assign terminal = (dir == DIR_UP) ? (digit_reg == MAX_DIGIT) : (digit_reg == '0);

endmodule

// File: rtl/multi_digit_counter.sv
// Cascaded modulo counter with up/down, clear, wrap/saturate and combinational overflow.
// Optional parallel load is enabled by defining MULTI_DIGIT_COUNTER_LOAD_EN.
module multi_digit_counter
  import multi_digit_counter_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10,
  parameter int WRAP   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enabled,
  input  logic                 up,
  input  logic                 clear,
`ifdef MULTI_DIGIT_COUNTER_LOAD_EN
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_value,
`endif
  output logic [DIGITS*DW-1:0] value,
  output logic                 overflow,
  output logic                 at_limit
);

  logic                 load_i;
  logic [DIGITS*DW-1:0] load_value_i;
  logic [DIGITS-1:0]    terminal;
  logic [DIGITS-1:0]    carry;
  logic                 accept;

`ifdef MULTI_DIGIT_COUNTER_LOAD_EN
  assign load_i       = load;
  assign load_value_i = load_value;
`else
  assign load_i       = 1'b0;
  assign load_value_i = '0;
`endif

  assign at_limit = &terminal;
  assign accept   = enabled & ~clear & ~load_i;
  assign overflow = accept & at_limit;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_first
        // In saturate mode a step at the range end is swallowed so the count holds.
        assign carry[0] = accept & ((WRAP != 0) | ~at_limit);
      end else begin : g_chain
        assign carry[gi] = carry[gi-1] & terminal[gi-1];
      end

      counter_digit #(
        .RADIX(RADIX)
      ) u_digit (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (carry[gi]),
        .up         (up),
        .clear      (clear),
        .load       (load_i),
        .load_digit (load_value_i[gi*DW +: DW]),
        .digit      (value[gi*DW +: DW]),
        .terminal   (terminal[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_digit_counter.sv
// Directed bench: two-digit decimal counters in wrap and saturate mode sharing stimulus,
// plus a single-digit modulo-4 counter.
module tb_multi_digit_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, clr;
  logic       ld;
  logic [7:0] ld_val;
  logic [7:0] value_w, value_s;
  logic       ov_w, ov_s, lim_w, lim_s;
  logic       en_s, up_s, clr_s;
  logic [3:0] value_1;
  logic       ov_1, lim_1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  multi_digit_counter #(.DIGITS(2), .RADIX(10), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enabled(en), .up(up), .clear(clr),
`ifdef MULTI_DIGIT_COUNTER_LOAD_EN
    .load(ld), .load_value(ld_val),
`endif
    .value(value_w), .overflow(ov_w), .at_limit(lim_w)
  );

  multi_digit_counter #(.DIGITS(2), .RADIX(10), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .enabled(en), .up(up), .clear(clr),
`ifdef MULTI_DIGIT_COUNTER_LOAD_EN
    .load(ld), .load_value(ld_val),
`endif
    .value(value_s), .overflow(ov_s), .at_limit(lim_s)
  );

  multi_digit_counter #(.DIGITS(1), .RADIX(4), .WRAP(1)) u_small (
    .clk(clk), .rst_n(rst_n), .enabled(en_s), .up(up_s), .clear(clr_s),
`ifdef MULTI_DIGIT_COUNTER_LOAD_EN
    .load(1'b0), .load_value(4'h0),
`endif
    .value(value_1), .overflow(ov_1), .at_limit(lim_1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  logic [3:0] seq_val [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
  logic       seq_ov  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0; en = 1'b1; up = 1'b0; clr = 1'b0; ld = 1'b0; ld_val = 8'h00;
    en_s = 1'b0; up_s = 1'b1; clr_s = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state: down direction sits at the limit, an enabled step underflows.
    check_eq("rst_value_w", 32'(value_w), 32'h00);
    check_eq("rst_value_s", 32'(value_s), 32'h00);
    check_eq("rst_limit_down", 32'(lim_w), 32'd1);
    check_eq("rst_ov_down", 32'(ov_w), 32'd1);
    up = 1'b1;
    #1;
    check_eq("rst_limit_up", 32'(lim_w), 32'd0);
    check_eq("rst_ov_up", 32'(ov_w), 32'd0);
    en = 1'b0;
    rst_n = 1'b1;

    // 00 -> 09 then carry into the tens digit.
    @(negedge clk);
    en = 1'b1; up = 1'b1;
    repeat (9) @(negedge clk);
    check_eq("count_09", 32'(value_w), 32'h09);
    check_eq("ov_at_09", 32'(ov_w), 32'd0);
    @(negedge clk);
    check_eq("carry_10", 32'(value_w), 32'h10);
    en = 1'b0;

    clr = 1'b1;
    #1;
    check_eq("ov_during_clear", 32'(ov_w), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    check_eq("clear_w", 32'(value_w), 32'h00);
    check_eq("clear_s", 32'(value_s), 32'h00);

    // Underflow from 00: wrap goes to 99, saturate holds at 00.
    en = 1'b1; up = 1'b0;
    #1;
    check_eq("uf_ov_w", 32'(ov_w), 32'd1);
    check_eq("uf_ov_s", 32'(ov_s), 32'd1);
    @(negedge clk);
    check_eq("uf_value_w", 32'(value_w), 32'h99);
    check_eq("uf_value_s", 32'(value_s), 32'h00);
    check_eq("sat_ov_again", 32'(ov_s), 32'd1);
    en = 1'b0;
    #1;
    check_eq("sat_ov_idle", 32'(ov_s), 32'd0);
    check_eq("sat_limit_idle", 32'(lim_s), 32'd1);

    // Overflow 99 -> 00, single-cycle pulse.
    en = 1'b1; up = 1'b1;
    #1;
    check_eq("of_limit_w", 32'(lim_w), 32'd1);
    check_eq("of_ov_w", 32'(ov_w), 32'd1);
    @(negedge clk);
    check_eq("of_value_w", 32'(value_w), 32'h00);
    check_eq("of_ov_cleared", 32'(ov_w), 32'd0);
    check_eq("sat_leaves_00", 32'(value_s), 32'h01);

    // Direction reversal takes effect on the same cycle's step.
    @(negedge clk);
    check_eq("dir_up_w", 32'(value_w), 32'h01);
    up = 1'b0;
    @(negedge clk);
    check_eq("dir_down_w", 32'(value_w), 32'h00);
    check_eq("dir_down_s", 32'(value_s), 32'h01);
    en = 1'b0;

`ifdef MULTI_DIGIT_COUNTER_LOAD_EN
    ld = 1'b1; ld_val = 8'h35;
    @(negedge clk);
    check_eq("load_35", 32'(value_w), 32'h35);
    ld_val = 8'h4C; en = 1'b1; up = 1'b1;
    #1;
    check_eq("load_ov", 32'(ov_w), 32'd0);
    @(negedge clk);
    check_eq("load_clamp_49", 32'(value_w), 32'h49);
    en = 1'b0; clr = 1'b1;
    @(negedge clk);
    check_eq("clear_beats_load", 32'(value_w), 32'h00);
    clr = 1'b0; ld = 1'b0;
`endif

    // Count to 57, then asynchronous reset between edges.
    en = 1'b1; up = 1'b1;
    repeat (57) @(negedge clk);
    en = 1'b0;
    check_eq("count_57", 32'(value_w), 32'h57);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_w", 32'(value_w), 32'h00);
    check_eq("async_rst_s", 32'(value_s), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    check_eq("resume_03_w", 32'(value_w), 32'h03);
    check_eq("resume_03_s", 32'(value_s), 32'h03);

    // Single digit modulo 4: 0,1,2,3,0 with overflow only at 3.
    en_s = 1'b1; up_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq($sformatf("mod4_val_%0d", i), 32'(value_1), 32'(seq_val[i]));
      check_eq($sformatf("mod4_ov_%0d", i), 32'(ov_1), 32'(seq_ov[i]));
      @(negedge clk);
    end
    en_s = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
